// File: rtl/adder_scheduler.sv
// Round-robin scheduler sharing one registered adder among NREQ requesters.
// One operation in flight; the result is returned tagged with the requester index.
module adder_scheduler #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int LAT   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*WIDTH-1:0]      req_a,
    input  logic [NREQ*WIDTH-1:0]      req_b,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    input  logic [WIDTH-1:0]           add_sum,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [WIDTH-1:0]           rsp_sum,
    output logic [15:0]                ops_done
);

    // state  | meaning
    // IDLE   | arbitrate among requesters, accept one operand pair
    // WAIT   | count down the adder register latency
    // SAMPLE | capture add_sum and the owner index into the response regs
    // RESP   | hold the response until rsp_ready
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;

    logic [1:0]       state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   id;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;

    logic             grant_found;
    logic [IDW-1:0]   grant;
    logic [IDW-1:0]   idx;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        idx         = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant       = idx;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && (state == S_IDLE) && grant_found) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign add_a = opa;
    assign add_b = opb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= IDW'(NREQ - 1);
            opa       <= '0;
            opb       <= '0;
            id        <= '0;
            cnt       <= '0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
            ops_done  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        opa   <= sel_a;
                        opb   <= sel_b;
                        id    <= grant;
                        ptr   <= grant;
                        cnt   <= CW'(LAT - 1);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_SAMPLE: begin
                    rsp_sum   <= add_sum;
                    rsp_id    <= id;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (ops_done != 16'hFFFF) begin
                            ops_done <= ops_done + 16'd1;
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/adder_scheduler.md
# adder_scheduler

Round-robin scheduler that shares one registered 8-bit adder among several requesters. It sits between the requester logic and the adder instance. It accepts one operand pair at a time over a valid/ready handshake, drives the adder inputs, waits out the adder's register latency, and returns the sum tagged with the requester index over a second valid/ready handshake. It also keeps a count of completed operations for debug readout on the user pins.

## Interface
Parameters:
- WIDTH, 8, operand and sum width
- NREQ, 4, number of requesters (2..8)
- LAT, 1, adder register latency in clock edges (≥1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept strobe, one-hot or zero
- req_a  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B; same packing as req_a
- add_a  out  WIDTH  adder operand A
- add_b  out  WIDTH  adder operand B
- add_sum  in  WIDTH  registered adder output
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumer ready
- rsp_id  out  clog2(NREQ)  index of the requester that owns the result
- rsp_sum  out  WIDTH  result
- ops_done  out  16  completed-operation count; saturates at 0xFFFF

## Operation
- FSM states:
  - IDLE
  - WAIT: holds a down-counter cnt
  - SAMPLE
  - RESP
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching ptr+1, ptr+2, … modulo NREQ.
  - req_ready[g]=1 is combinational from req_valid. It is only asserted in IDLE.
  - Acceptance edge (req_valid[g] & req_ready[g]):
    - opa←req_a[g], opb←req_b[g], id←g, ptr←g
    - cnt←LAT-1, state←WAIT
  - No request: remain in IDLE.
- add_a=opa and add_b=opb at all times. They are registered, so the outputs are glitch-free.
- WAIT:
  - If cnt==0, state←SAMPLE.
  - Otherwise cnt←cnt-1.
- SAMPLE:
  - rsp_sum←add_sum, rsp_id←id, rsp_valid←1, state←RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_sum are held stable until rsp_ready=1 at an edge.
  - On that edge: rsp_valid←0, ops_done←ops_done+1 (saturating), state←IDLE.
- Arithmetic: sum = (a+b) mod 2^WIDTH. The carry is discarded, and no overflow flag is produced.
- Requesters must hold req_valid and operands until req_ready. A requester that deasserts req_valid before it is granted is simply skipped; arbitration is re-evaluated every IDLE cycle.
- Only one operation is in flight. No request is accepted in WAIT, SAMPLE or RESP.
- Reset (rst_n=0 at an edge), from any state:
  - state←IDLE, ptr←NREQ-1 (requester 0 has first priority)
  - opa, opb, id, cnt, rsp_sum, rsp_id ← 0
  - rsp_valid←0, ops_done←0
  - req_ready is 0 while rst_n=0.
  - An in-flight operation is dropped and produces no response. add_sum from a dropped operation is never sampled.

## Timing
- Acceptance on edge E:
  - add_a/add_b carry the new operands from E.
  - The adder captures on edge E+LAT.
  - SAMPLE occupies the cycle after E+LAT.
  - rsp_valid=1 from edge E+LAT+1.
- With rsp_ready tied high:
  - The response handshake occurs on edge E+LAT+2.
  - IDLE is re-entered, and the next acceptance occurs no earlier than edge E+LAT+3.
  - Sustained throughput is one operation per LAT+3 cycles.
- Back-pressure: each cycle of rsp_ready=0 in RESP adds one cycle to the period. There is no cap on the stall.
- Simultaneous rsp_ready and new req_valid in RESP: the response completes; the request is evaluated in the following IDLE cycle.
- ops_done updates on the response-handshake edge.

## Test plan
- Reset: hold rst_n=0 for 2 edges with every req_valid=1.
  - Required: req_ready=0, rsp_valid=0, add_a=add_b=0, ops_done=0.
  - Required: the first grant after release goes to requester 0.
- Single op: requester 2 presents a=0x12, b=0x34; rsp_ready=1.
  - Required: accepted on edge E; rsp_valid=1 from E+2 (LAT=1) with rsp_id=2 and rsp_sum=0x46.
  - Required: ops_done=1 after the handshake.
- Wrap: a=0xF0, b=0x20 → rsp_sum=0x10. Also a=0xFF, b=0x01 → rsp_sum=0x00.
- Fairness: all four requesters hold valid with distinct operands; rsp_ready=1.
  - Required: grant order 0,1,2,3,0,1; accept edges exactly 4 cycles apart (LAT=1); each rsp_id/rsp_sum pair matches its requester.
- Back-pressure: hold rsp_ready=0 for 5 cycles after rsp_valid rises while other requests are pending.
  - Required: rsp_id and rsp_sum stay constant, and req_ready stays 0.
  - Required: the next accept occurs exactly one IDLE cycle after the handshake.
- Reset mid-operation: assert rst_n=0 for one edge during WAIT.
  - Required: no rsp_valid pulse and ops_done=0.
  - Required: a following op with a=0x05, b=0x07 returns 0x0C with correct latency.
